piso_stream_serializer: RTL

//  Parametrised parallel-in/serial-out serializer with valid/ready on both sides.

---
 rtl/piso_stream_serializer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/piso_stream_serializer.sv
`timescale 1ns/1ps
// piso_stream_serializer
//   Parallel-in/serial-out serializer with valid/ready handshakes on both sides.
//   An N-bit word is accepted into a one-word holding register. It is then moved
//   into the shifter and sent one bit per cycle, MSB- or LSB-first. The holding
//   register lets the next word wait while the current frame is sent, so
//   back-to-back frames leave no idle cycle between them.
//
// Parameters
//   N          data word width (N >= 2)
//   MSB_FIRST  1: in_data[N-1] is sent first, 0: in_data[0] is sent first
//
// Configuration macro
//   PISO_PARITY_EN  when defined, each frame carries N data bits followed by one
//                   even-parity bit (^word). out_last marks the parity bit.
//                   When undefined, a frame is exactly N bits.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous reset, active low
//   in_valid   producer presents a word on in_data
//   in_ready   holding register is free; a word is taken when in_valid & in_ready
//   in_data    parallel word
//   out_ready  sink takes out_bit this cycle
//   out_valid  out_bit is valid
//   out_bit    serial data bit
//   out_first  first bit of a frame
//   out_last   last bit of a frame
//   busy       shifter or holding register occupied
//
// state | meaning
// IDLE  | shifter empty, waiting for the holding register to fill
// SHIFT | frame in progress, out_valid asserted
module piso_stream_serializer #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic         out_bit,
  output logic         out_first,
  output logic         out_last,
  output logic         busy
);

`ifdef PISO_PARITY_EN
  localparam int FRAME = N + 1;
`else
  localparam int FRAME = N;
`endif
  localparam int            CW       = $clog2(N + 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  hold_q, hold_d;
  logic [N-1:0]  shift_q, shift_d;
  logic          hold_full_q, hold_full_d;
  logic          in_ready_q, in_ready_d;
  logic [CW-1:0] cnt_q, cnt_d;
`ifdef PISO_PARITY_EN
  logic          par_q, par_d;
`endif

  logic accept;
  logic xfer;
  logic at_last;
  logic load;
  logic data_bit;
  logic serial_bit;

  always_comb begin
    accept  = in_valid & in_ready_q;
    xfer    = (state_q == SHIFT) & out_ready;
    at_last = (cnt_q == CNT_LAST);
    // Shifter loads from hold either when idle or on the final bit transfer,
    // the latter giving gap-free streaming.
    load    = hold_full_q & ((state_q == IDLE) | (xfer & at_last));

    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
`ifdef PISO_PARITY_EN
    par_d       = par_q;
`endif

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (xfer) begin
          if (at_last) begin
            cnt_d = '0;
            if (!hold_full_q) state_d = IDLE;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            shift_d = MSB_FIRST ? {shift_q[N-2:0], 1'b0} : {1'b0, shift_q[N-1:1]};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
`ifdef PISO_PARITY_EN
      par_d       = ^hold_q;
`endif
    end

    // Applied after the reload so a same-edge accept lands in hold while the
    // shifter takes the previous hold contents.
    if (accept) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end

    in_ready_d = ~hold_full_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
`ifdef PISO_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign data_bit = MSB_FIRST ? shift_q[N-1] : shift_q[0];

`ifdef PISO_PARITY_EN
  assign serial_bit = (cnt_q == CW'(N)) ? par_q : data_bit;
`else
  assign serial_bit = data_bit;
`endif

  assign out_valid = (state_q == SHIFT);
  assign out_bit   = out_valid & serial_bit;
  assign out_first = out_valid & (cnt_q == '0);
  assign out_last  = out_valid & at_last;
  assign busy      = out_valid | hold_full_q;
  assign in_ready  = in_ready_q;

endmodule
